// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;
    typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_t;
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    localparam int ITERS = 32;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: 33-cycle iterative MULT/MULTU/DIV/DIVU with architectural HI/LO registers.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(ITERS);
    state_t             st;
    logic               dv, sa, sb, bz;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   ma, mb;
    logic [2*WIDTH-1:0] acc, mul_nx, div_nx, prod;
    logic [WIDTH:0]     t;
    logic [WIDTH-1:0]   diff, quo, rem;
    logic               sgn, ge;
    assign busy = st != IDLE;
    always_comb begin
        sgn    = op == OP_MULT || op == OP_DIV;
        // multiply consumes the multiplier MSB-first; divide shifts dividend bits into the remainder
        mul_nx = {acc[2*WIDTH-2:0], 1'b0} + (mb[WIDTH-1] ? {{WIDTH{1'b0}}, ma} : '0);
        t      = {acc[2*WIDTH-1:WIDTH], ma[WIDTH-1]};
        ge     = t >= {1'b0, mb};
        diff   = t[WIDTH-1:0] - mb;
        div_nx = {ge ? diff : t[WIDTH-1:0], acc[WIDTH-2:0], ge};
        prod   = sa ^ sb ? -acc : acc;
        quo    = bz ? '1 : (sa ^ sb ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem    = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= IDLE;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            ma   <= '0;
            mb   <= '0;
            dv   <= 1'b0;
            sa   <= 1'b0;
            sb   <= 1'b0;
            bz   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (start) begin
                        dv  <= op[1];
                        sa  <= sgn & a[WIDTH-1];
                        sb  <= sgn & b[WIDTH-1];
                        bz  <= op[1] && b == '0;
                        ma  <= sgn && a[WIDTH-1] ? -a : a;
                        mb  <= sgn && b[WIDTH-1] ? -b : b;
                        acc <= '0;
                        cnt <= '0;
                        st  <= RUN;
                    end else begin
                        if (mthi) hi <= wd;
                        if (mtlo) lo <= wd;
                    end
                end
                RUN: begin
                    acc <= dv ? div_nx : mul_nx;
                    ma  <= dv ? ma << 1 : ma;
                    mb  <= dv ? mb : mb << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITERS - 1)) st <= FIX;
                end
                default: begin
                    hi   <= dv ? rem : prod[2*WIDTH-1:WIDTH];
                    lo   <= dv ? quo : prod[WIDTH-1:0];
                    done <= 1'b1;
                    st   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 0, rst = 1, start = 0, mthi = 0, mtlo = 0;
    logic [1:0]  op = 0;
    logic [31:0] a = 0, b = 0, wd = 0;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic [63:0] pend, held;
    int checks = 0, failures = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p, q, r;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: begin p = sx * sy; return p; end
            2'b01: begin u = {32'b0, x} * {32'b0, y}; return u; end
            2'b10: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: return y == 0 ? {x, 32'hFFFFFFFF} : {x % y, x / y};
        endcase
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1; op = o; a = x; b = y;
        pend = model(o, x, y);
        @(posedge clk); #1;
        start = 0; a = $urandom; b = $urandom;
    endtask

    task automatic finish_op(input string tag, input bit disturb);
        int n = 0, nb = 0;
        while (!done && n < 40) begin
            nb += int'(busy);
            if (n == 3) check({tag, " hold"}, {hi, lo}, held);
            if (disturb && n == 5) begin start = 1; mthi = 1; mtlo = 1; op = 2'($urandom); wd = $urandom; end
            if (disturb && n == 6) begin start = 0; mthi = 0; mtlo = 0; end
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd33);
        check({tag, " busycnt"}, 64'(nb), 64'd33);
        check({tag, " busy@done"}, 64'(busy), 64'd0);
        check({tag, " hilo"}, {hi, lo}, pend);
        held = pend;
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] x, y;
        bit seen;
        repeat (2) @(posedge clk); #1;
        check("reset hilo", {hi, lo}, 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        rst = 0;
        held = 0;
        launch(2'b00, 32'hFFFFFFFD, 32'd7);
        finish_op("mult_neg", 0);
        @(posedge clk); #1;
        check("done pulse", 64'(done), 64'd0);
        launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        finish_op("multu_max", 0);
        launch(2'b10, 32'hFFFFFFF9, 32'd2);
        finish_op("div_neg", 0);
        launch(2'b11, 32'd100, 32'd0);
        finish_op("divu_zero", 0);
        launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
        finish_op("div_ovf", 0);
        launch(2'b01, $urandom, $urandom);
        finish_op("b2b", 0);
        launch(2'b10, $urandom, 32'd0);
        finish_op("div_zero", 0);
        launch(2'b00, $urandom, $urandom);
        finish_op("disturb", 1);
        @(posedge clk); #1;
        mthi = 1; mtlo = 1; wd = 32'h12345678;
        @(posedge clk); #1;
        mthi = 0; mtlo = 0;
        check("mthi_mtlo", {hi, lo}, 64'h12345678_12345678);
        mthi = 1; wd = 32'hCAFEF00D;
        @(posedge clk); #1;
        mthi = 0;
        check("mthi_only", {hi, lo}, 64'hCAFEF00D_12345678);
        held = {hi, lo};
        mtlo = 1; wd = 32'hDEADBEEF;
        launch(2'b11, $urandom, $urandom_range(1, 1000));
        mtlo = 0;
        check("start_prio", {hi, lo}, held);
        finish_op("prio_op", 0);
        for (int i = 0; i < 20; i++) begin
            o = 2'($urandom);
            x = (i % 3 == 0) ? $urandom_range(0, 50) : $urandom;
            y = (i % 5 == 0) ? 32'd0 : ((i % 4 == 0) ? 32'hFFFFFFFF : $urandom);
            launch(o, x, y);
            finish_op($sformatf("rand%0d", i), i % 7 == 3);
            if (i % 2 == 0) begin @(posedge clk); #1; end
        end
        launch(2'b00, $urandom, $urandom);
        repeat (9) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hilo", {hi, lo}, 64'd0);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; seen |= done; end
        check("abort nodone", 64'(seen), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
